alu_seq: RTL and testbench

//   Parametrised multi-cycle ALU for the MIPS datapath, issued from the execute stage.

---
 rtl/alu_seq_if.sv | 46 ++++
 rtl/alu_seq.sv | 236 +++++++++++++++++++++++
 tb/tb_alu_seq.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// alu_seq_if: issue/result bundle between the execute stage and the ALU.
//
// Handshake rules (both directions): a transfer happens on a rising clock
// edge where valid and ready are both high. The sender holds valid and its
// payload stable until the transfer. The receiver may drive ready without
// looking at valid.
//   - issue side : in_valid / in_ready, payload read_data1, read_data2,
//                  sign_extend, ALU_Src, alu_op, alu_funct
//   - result side: out_valid / out_ready, payload result, hi, zero,
//                  overflow, div_by_zero, branch_value
//
// master: the issuing/consuming stage. slave: the ALU.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] read_data1;
  logic [WIDTH-1:0] read_data2;
  logic [WIDTH-1:0] sign_extend;
  logic             ALU_Src;
  logic [1:0]       alu_op;
  logic [5:0]       alu_funct;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] hi;
  logic             zero;
  logic             overflow;
  logic             div_by_zero;
  logic [WIDTH-1:0] branch_value;

  modport master (
    output in_valid, read_data1, read_data2, sign_extend, ALU_Src, alu_op,
           alu_funct, out_ready,
    input  in_ready, out_valid, result, hi, zero, overflow, div_by_zero,
           branch_value
  );

  modport slave (
    input  in_valid, read_data1, read_data2, sign_extend, ALU_Src, alu_op,
           alu_funct, out_ready,
    output in_ready, out_valid, result, hi, zero, overflow, div_by_zero,
           branch_value
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU for the MIPS execute stage.
//   One operation per in_valid/in_ready transfer. ADD/SUB/AND/OR/SLT and
//   unknown functs finish in one cycle; MULT (unsigned shift-add) and DIV
//   (unsigned restoring) take WIDTH iterations. Results are held until the
//   consumer takes them with out_valid/out_ready.
//
// Ports:
//   clock      rising-edge clock
//   reset_n    synchronous reset, active low
//   bus        alu_seq_if.slave: issue operands/op, result outputs
//   state_dbg  current FSM state (IDLE=0, MUL=1, DIV=2, DONE=3)
//
// Build option: ALU_DIV_EN builds the divider. Without it, funct 011010 is
// treated as an unknown funct and div_by_zero is tied to 0.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic       clock,
  input  logic       reset_n,
  alu_seq_if.slave   bus,
  output logic [1:0] state_dbg
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [2:0] K_ADD = 3'd0;
  localparam logic [2:0] K_SUB = 3'd1;
  localparam logic [2:0] K_AND = 3'd2;
  localparam logic [2:0] K_OR  = 3'd3;
  localparam logic [2:0] K_SLT = 3'd4;
  localparam logic [2:0] K_MUL = 3'd5;
  localparam logic [2:0] K_DIV = 3'd6;
  localparam logic [2:0] K_UNK = 3'd7;

  localparam int CW = $clog2(WIDTH);

  logic [1:0]         state;
  logic [WIDTH-1:0]   a_reg;
  // MUL: {partial product high, multiplier shifting out}.
  // DIV: {partial remainder, dividend shifting out / quotient shifting in}.
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   result_q, hi_q, bv_q;
  logic               zero_q, ovf_q, out_valid_q;

  logic [WIDTH-1:0]   op_a, op_b, sum, dif, sc_result;
  logic               sc_ovf, last_iter;
  logic [2:0]         kind;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  assign op_a = bus.read_data1;
  assign op_b = bus.ALU_Src ? bus.sign_extend : bus.read_data2;
  assign sum  = op_a + op_b;
  assign dif  = op_a - op_b;
  assign last_iter = (count == CW'(WIDTH - 1));

  always_comb begin
    kind = K_UNK;
    case (bus.alu_op)
      2'b00: kind = K_ADD;
      2'b01: kind = K_SUB;
      default: begin
        case (bus.alu_funct)
          6'b100100: kind = K_AND;
          6'b100101: kind = K_OR;
          6'b100000: kind = K_ADD;
          6'b100010: kind = K_SUB;
          6'b101010: kind = K_SLT;
          6'b011000: kind = K_MUL;
          6'b011010: kind = K_DIV;
          default:   kind = K_UNK;
        endcase
      end
    endcase
  end

  // One-cycle results. Anything not listed (unknown, or DIV without the
  // divider) yields 0.
  always_comb begin
    sc_result = '0;
    sc_ovf    = 1'b0;
    case (kind)
      K_ADD: begin
        sc_result = sum;
        sc_ovf    = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
      end
      K_SUB: begin
        sc_result = dif;
        sc_ovf    = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (dif[WIDTH-1] != op_a[WIDTH-1]);
      end
      K_AND:   sc_result = op_a & op_b;
      K_OR:    sc_result = op_a | op_b;
      K_SLT:   sc_result = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      default: sc_result = '0;
    endcase
  end

  // Shift-add step: add the multiplicand into the high half when the
  // current multiplier bit is set, then shift the whole pair right.
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_reg} : '0);
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

`ifdef ALU_DIV_EN
  logic [WIDTH-1:0]   b_reg;
  logic [WIDTH:0]     div_shift, div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_next;
  logic               dbz_q;

  // Restoring step: shift in the next dividend bit, keep the difference
  // only when it did not go negative; that decision is the quotient bit.
  assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, b_reg};
  assign div_ge    = ~div_diff[WIDTH];
  assign div_next  = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                      acc[WIDTH-2:0], div_ge};
  assign bus.div_by_zero = dbz_q;
`else
  assign bus.div_by_zero = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      a_reg       <= '0;
      acc         <= '0;
      count       <= '0;
      result_q    <= '0;
      hi_q        <= '0;
      bv_q        <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef ALU_DIV_EN
      b_reg       <= '0;
      dbz_q       <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            a_reg <= op_a;
            bv_q  <= bus.sign_extend;
            count <= '0;
            case (kind)
              K_MUL: begin
                acc   <= {{WIDTH{1'b0}}, op_b};
                state <= S_MUL;
              end
`ifdef ALU_DIV_EN
              K_DIV: begin
                if (op_b == '0) begin
                  result_q    <= '1;
                  hi_q        <= op_a;
                  zero_q      <= 1'b0;
                  ovf_q       <= 1'b0;
                  dbz_q       <= 1'b1;
                  out_valid_q <= 1'b1;
                  state       <= S_DONE;
                end else begin
                  b_reg <= op_b;
                  acc   <= {{WIDTH{1'b0}}, op_a};
                  state <= S_DIV;
                end
              end
`endif
              default: begin
                result_q    <= sc_result;
                hi_q        <= '0;
                zero_q      <= (sc_result == '0);
                ovf_q       <= sc_ovf;
`ifdef ALU_DIV_EN
                dbz_q       <= 1'b0;
`endif
                out_valid_q <= 1'b1;
                state       <= S_DONE;
              end
            endcase
          end
        end
        S_MUL: begin
          acc   <= mul_next;
          count <= count + 1'b1;
          if (last_iter) begin
            hi_q        <= mul_next[2*WIDTH-1:WIDTH];
            result_q    <= mul_next[WIDTH-1:0];
            zero_q      <= (mul_next[WIDTH-1:0] == '0);
            ovf_q       <= 1'b0;
`ifdef ALU_DIV_EN
            dbz_q       <= 1'b0;
`endif
            out_valid_q <= 1'b1;
            state       <= S_DONE;
          end
        end
        S_DIV: begin
`ifdef ALU_DIV_EN
          acc   <= div_next;
          count <= count + 1'b1;
          if (last_iter) begin
            hi_q        <= div_next[2*WIDTH-1:WIDTH];
            result_q    <= div_next[WIDTH-1:0];
            zero_q      <= (div_next[WIDTH-1:0] == '0);
            ovf_q       <= 1'b0;
            dbz_q       <= 1'b0;
            out_valid_q <= 1'b1;
            state       <= S_DONE;
          end
`else
          // Unreachable without the divider; recover to IDLE.
          state <= S_IDLE;
`endif
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready     = (state == S_IDLE) & reset_n;
  assign bus.out_valid    = out_valid_q;
  assign bus.result       = result_q;
  assign bus.hi           = hi_q;
  assign bus.zero         = zero_q;
  assign bus.overflow     = ovf_q;
  assign bus.branch_value = bv_q;
  assign state_dbg        = state;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed-vector bench for alu_seq (WIDTH=32).
// Inputs change #1 after the rising edge; outputs are sampled there too.
module tb_alu_seq;
  localparam int W = 32;

  logic       clock;
  logic       reset_n;
  logic [1:0] state_dbg;
  int         checks;
  int         errors;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // driver: present one op and complete the accept edge
  task automatic issue(input logic [1:0] op, input logic [5:0] fn, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] se, input logic src);
    int n;
    bus.alu_op      = op;
    bus.alu_funct   = fn;
    bus.read_data1  = a;
    bus.read_data2  = b;
    bus.sign_extend = se;
    bus.ALU_Src     = src;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      tick();
      n++;
    end
    if (!bus.in_ready) check("in_ready_wait", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  // count edges from the accept edge (inclusive) until out_valid is seen
  task automatic wait_done(output int lat, output bit ready_seen);
    lat = 1;
    ready_seen = 1'b0;
    while (!bus.out_valid && lat < 100) begin
      if (bus.in_ready) ready_seen = 1'b1;
      tick();
      lat++;
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [5:0] fn, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] se, input logic src,
                        output int lat, output bit ready_seen);
    issue(op, fn, a, b, se, src);
    wait_done(lat, ready_seen);
  endtask

  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_MULT = 6'b011000;
  localparam logic [5:0] F_DIV  = 6'b011010;

  initial begin
    int lat;
    bit rdy;
    bit seen;
    checks = 0;
    errors = 0;
    reset_n         = 1'b0;
    bus.in_valid    = 1'b0;
    bus.out_ready   = 1'b1;
    bus.read_data1  = '0;
    bus.read_data2  = '0;
    bus.sign_extend = '0;
    bus.ALU_Src     = 1'b0;
    bus.alu_op      = 2'b00;
    bus.alu_funct   = 6'b0;

    // reset state
    repeat (3) tick();
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_result", 64'(bus.result), 64'd0);
    check("rst_hi", 64'(bus.hi), 64'd0);
    check("rst_flags", {61'd0, bus.zero, bus.overflow, bus.div_by_zero}, 64'd0);
    check("rst_bv", 64'(bus.branch_value), 64'd0);
    check("rst_state", 64'(state_dbg), 64'd0);
    reset_n = 1'b1;
    #1;
    check("idle_in_ready", 64'(bus.in_ready), 64'd1);

    // ADD
    run_op(2'b10, F_ADD, 32'd25, 32'd25, 32'd0, 1'b0, lat, rdy);
    check("add_lat", 64'(lat), 64'd1);
    check("add_result", 64'(bus.result), 64'd50);
    check("add_zero_ovf", {62'd0, bus.zero, bus.overflow}, 64'd0);
    run_op(2'b10, F_ADD, 32'h7FFF_FFFF, 32'd1, 32'd0, 1'b0, lat, rdy);
    check("addovf_result", 64'(bus.result), 64'h8000_0000);
    check("addovf_ovf", 64'(bus.overflow), 64'd1);

    // compare-subtract and immediate add
    run_op(2'b01, 6'd0, 32'd25, 32'd25, 32'd64, 1'b0, lat, rdy);
    check("beq_result", 64'(bus.result), 64'd0);
    check("beq_zero", 64'(bus.zero), 64'd1);
    check("beq_bv", 64'(bus.branch_value), 64'd64);
    run_op(2'b00, 6'd0, 32'd10, 32'd999, 32'd64, 1'b1, lat, rdy);
    check("addi_result", 64'(bus.result), 64'd74);
    check("addi_zero", 64'(bus.zero), 64'd0);
    run_op(2'b10, F_SUB, 32'h8000_0000, 32'd1, 32'd0, 1'b0, lat, rdy);
    check("subovf_result", 64'(bus.result), 64'h7FFF_FFFF);
    check("subovf_ovf", 64'(bus.overflow), 64'd1);
    run_op(2'b10, F_AND, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 1'b0, lat, rdy);
    check("and_result", 64'(bus.result), 64'h0000_F000);
    check("and_ovf", 64'(bus.overflow), 64'd0);
    run_op(2'b10, F_OR, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 1'b0, lat, rdy);
    check("or_result", 64'(bus.result), 64'h0000_FFF0);

    // MULT
    run_op(2'b10, F_MULT, 32'hFFFF_FFFF, 32'd2, 32'd0, 1'b0, lat, rdy);
    check("mul_lat", 64'(lat), 64'd33);
    check("mul_busy_ready", 64'(rdy), 64'd0);
    check("mul_hi", 64'(bus.hi), 64'd1);
    check("mul_result", 64'(bus.result), 64'hFFFF_FFFE);
    run_op(2'b10, F_MULT, 32'h1234_5678, 32'h10, 32'd0, 1'b0, lat, rdy);
    check("mul2_prod", {32'(bus.hi), 32'(bus.result)}, 64'h0000_0001_2345_6780);

    // unknown funct clears hi left by MULT
    run_op(2'b10, 6'b111111, 32'd9, 32'd9, 32'd0, 1'b0, lat, rdy);
    check("unk_lat", 64'(lat), 64'd1);
    check("unk_result_hi", {32'(bus.hi), 32'(bus.result)}, 64'd0);
    check("unk_zero", 64'(bus.zero), 64'd1);

    // DIV
`ifdef ALU_DIV_EN
    run_op(2'b10, F_DIV, 32'd100, 32'd7, 32'd0, 1'b0, lat, rdy);
    check("div_lat", 64'(lat), 64'd33);
    check("div_q_r", {32'(bus.hi), 32'(bus.result)}, {32'd2, 32'd14});
    check("div_dbz", 64'(bus.div_by_zero), 64'd0);
    run_op(2'b10, F_DIV, 32'd5, 32'd0, 32'd0, 1'b0, lat, rdy);
    check("div0_lat", 64'(lat), 64'd1);
    check("div0_q_r", {32'(bus.hi), 32'(bus.result)}, {32'd5, 32'hFFFF_FFFF});
    check("div0_dbz", 64'(bus.div_by_zero), 64'd1);
`else
    run_op(2'b10, F_DIV, 32'd100, 32'd7, 32'd0, 1'b0, lat, rdy);
    check("nodiv_lat", 64'(lat), 64'd1);
    check("nodiv_result", 64'(bus.result), 64'd0);
    check("nodiv_dbz", 64'(bus.div_by_zero), 64'd0);
    run_op(2'b10, F_DIV, 32'd5, 32'd0, 32'd0, 1'b0, lat, rdy);
    check("nodiv0_dbz", 64'(bus.div_by_zero), 64'd0);
`endif

    // SLT is signed
    run_op(2'b10, F_SLT, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, lat, rdy);
    check("slt_pos_neg", 64'(bus.result), 64'd0);
    run_op(2'b10, F_SLT, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, lat, rdy);
    check("slt_neg_pos", 64'(bus.result), 64'd1);

    // back-pressure: hold 5 cycles
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_out_valid", 64'(bus.out_valid), 64'd1);
      check("hold_in_ready", 64'(bus.in_ready), 64'd0);
      check("hold_result", 64'(bus.result), 64'd1);
    end
    bus.out_ready = 1'b1;
    tick();
    check("release_out_valid", 64'(bus.out_valid), 64'd0);
    check("release_state", 64'(state_dbg), 64'd0);
    check("release_keep_result", 64'(bus.result), 64'd1);

    // reset in the middle of a MULT
    run_op(2'b10, F_OR, 32'h0000_F0F0, 32'h0000_FF00, 32'h55, 1'b0, lat, rdy);
    tick();
    issue(2'b10, F_MULT, 32'd1234, 32'd5678, 32'h77, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (bus.out_valid) seen = 1'b1;
      tick();
    end
    reset_n = 1'b0;
    tick();
    check("abort_out_valid", 64'(bus.out_valid), 64'd0);
    check("abort_result_hi", {32'(bus.hi), 32'(bus.result)}, 64'd0);
    check("abort_bv", 64'(bus.branch_value), 64'd0);
    check("abort_in_ready", 64'(bus.in_ready), 64'd0);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (bus.out_valid) seen = 1'b1;
      tick();
    end
    check("abort_no_valid", 64'(seen), 64'd0);
    run_op(2'b10, F_ADD, 32'd3, 32'd4, 32'd0, 1'b0, lat, rdy);
    check("post_reset_lat", 64'(lat), 64'd1);
    check("post_reset_add", 64'(bus.result), 64'd7);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
